// File: rtl/typ_tile_compute_pkg.sv
// Shared encodings and helpers for the typed tile compute unit.
package typ_tile_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MUL    = 2'd2,
    OP_MATMUL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Bit offset of element (r,c) inside a row-major NxN tile of W-bit elements.
  function automatic int elem_off(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/typ_tile_compute_if.sv
// Operand/result handshake bundle of the typed tile compute unit.
interface typ_tile_compute_if #(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int CNT_W = 32
);
  logic               io_in_valid;
  logic               io_in_ready;
  logic [N*N*W-1:0]   io_in_bits_left;
  logic [N*N*W-1:0]   io_in_bits_right;
  logic [1:0]         io_in_bits_op;
  logic               io_out_valid;
  logic               io_out_ready;
  logic [N*N*W-1:0]   io_out_bits_data;
  logic [1:0]         io_out_bits_op;
  logic [CNT_W-1:0]   io_opCount;

  modport master (
    output io_in_valid, io_in_bits_left, io_in_bits_right, io_in_bits_op, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_op, io_opCount
  );

  modport slave (
    input  io_in_valid, io_in_bits_left, io_in_bits_right, io_in_bits_op, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_data, io_out_bits_op, io_opCount
  );
endinterface

// File: rtl/typ_tile_compute_elem_alu.sv
// Per-element ALU: add/sub/mul, or multiply-accumulate when i_acc_en is set.
module typ_elem_alu
  import typ_tile_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_acc,
  input  op_e          i_op,
  input  logic         i_acc_en,
  output logic [W-1:0] o_res
);

  logic [W-1:0] w_prod;

  // Only the low W bits of the product are ever needed.
  assign w_prod = i_a * i_b;

  always_comb begin
    o_res = i_a + i_b;
    if (i_acc_en) begin
      o_res = i_acc + w_prod;
    end else begin
      case (i_op)
        OP_SUB:  o_res = i_a - i_b;
        OP_MUL:  o_res = w_prod;
        default: o_res = i_a + i_b;
      endcase
    end
  end

endmodule

// File: rtl/typ_tile_compute.sv
// Typed tile compute unit: element-wise add/sub/mul in one cycle, NxN matmul one k per cycle.
module typ_tile_compute
  import typ_tile_pkg::*;
#(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  typ_tile_compute_if.slave bus
);

  localparam int NE = N * N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  state_e                r_state, w_state_nxt;
  logic [KW-1:0]         r_k;
  logic [NE*W-1:0]       r_left, r_right;
  op_e                   r_op;
  logic [NE-1:0][W-1:0]  r_acc;
  logic [NE-1:0][W-1:0]  w_res;
  logic [NE*W-1:0]       r_out_data;
  logic [1:0]            r_out_op;
  logic [CNT_W-1:0]      r_cnt;

  logic w_in_fire, w_out_fire, w_last, w_acc_en, w_in_ready;
  op_e  w_in_op, w_alu_op;

  assign w_in_ready = (r_state == IDLE) && !reset;
  assign w_in_fire  = bus.io_in_valid && w_in_ready;
  assign w_out_fire = (r_state == DONE) && bus.io_out_ready;
  assign w_last     = (r_k == KW'(N - 1));
  assign w_in_op    = op_e'(bus.io_in_bits_op);
  assign w_acc_en   = (r_state == COMPUTE);
  assign w_alu_op   = (r_state == IDLE) ? w_in_op : r_op;

  // In IDLE the ALUs see the incoming tiles directly; in COMPUTE they see column k / row k.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      localparam int EI = gr * N + gc;
      logic [W-1:0] w_a, w_b;

      always_comb begin
        if (r_state == COMPUTE) begin
          w_a = r_left[elem_off(gr, int'(r_k), N, W) +: W];
          w_b = r_right[elem_off(int'(r_k), gc, N, W) +: W];
        end else begin
          w_a = bus.io_in_bits_left[EI*W +: W];
          w_b = bus.io_in_bits_right[EI*W +: W];
        end
      end

      typ_elem_alu #(.W(W)) u_alu (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_acc   (r_acc[EI]),
        .i_op    (w_alu_op),
        .i_acc_en(w_acc_en),
        .o_res   (w_res[EI])
      );
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_fire) w_state_nxt = (w_in_op == OP_MATMUL) ? COMPUTE : DONE;
      COMPUTE: if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_out_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_k        <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_op       <= OP_ADD;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_op   <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_in_fire) begin
        r_left  <= bus.io_in_bits_left;
        r_right <= bus.io_in_bits_right;
        r_op    <= w_in_op;
        r_k     <= '0;
        r_acc   <= '0;
        if (w_in_op != OP_MATMUL) begin
          r_out_data <= w_res;
          r_out_op   <= bus.io_in_bits_op;
        end
      end
      if (r_state == COMPUTE) begin
        r_acc <= w_res;
        if (w_last) begin
          r_k        <= '0;
          r_out_data <= w_res;
          r_out_op   <= r_op;
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
      if (w_out_fire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.io_in_ready      = w_in_ready;
  assign bus.io_out_valid     = (r_state == DONE);
  assign bus.io_out_bits_data = r_out_data;
  assign bus.io_out_bits_op   = r_out_op;
  assign bus.io_opCount       = r_cnt;

endmodule

// File: doc/typ_tile_compute.md
Name: typ_tile_compute

Overview:
Parametrised successor to the fixed 2x2 typed operator unit. Accepts two NxN tiles of W-bit elements over a ready/valid handshake and applies one of four operations: element-wise add, sub or mul, or matrix multiply. The result tile is returned over a second ready/valid handshake. It sits under the typed-memory dataflow top as the typed compute functional unit, between the tile load path and the store path.

Parameters:
N, 2, tile dimension; the tile holds N*N elements; N >= 1.
W, 32, element width in bits; all arithmetic is unsigned modulo 2^W.
CNT_W, 32, width of the completed-operation counter.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-high reset.
io_in_valid  in  1  operand tile pair is valid.
io_in_ready  out  1  unit can accept an operand pair.
io_in_bits_left  in  N*N*W  left tile; element (r,c) occupies bits [(r*N+c)*W +: W].
io_in_bits_right  in  N*N*W  right tile; same layout as the left tile.
io_in_bits_op  in  2  0=ADD, 1=SUB (left-right), 2=MUL (element-wise), 3=MATMUL (left x right).
io_out_valid  out  1  result tile is valid.
io_out_ready  in  1  consumer accepts the result.
io_out_bits_data  out  N*N*W  result tile; same layout as the operand tiles.
io_out_bits_op  out  2  op that produced the result.
io_opCount  out  CNT_W  number of completed output handshakes; wraps at 2^CNT_W.

Behaviour:
- State machine: IDLE, COMPUTE, DONE.
- Reset (asynchronous, active-high):
  - state=IDLE, io_out_valid=0, io_out_bits_data=0, io_out_bits_op=0, io_opCount=0, k=0.
  - io_in_ready is forced to 0 while reset is high.
- io_in_ready = (state==IDLE) && !reset. An input handshake is io_in_valid && io_in_ready.
- IDLE, on input handshake at cycle t:
  - Latch left, right and op.
  - ADD/SUB/MUL: compute all N*N elements combinationally and register the result. Go to DONE; io_out_valid=1 at t+1 (latency 1).
  - MATMUL: clear the accumulator and set k=0. Go to COMPUTE.
- COMPUTE, one k per cycle on cycles t+1..t+N:
  - Update acc[r][c] = acc[r][c] + left[r][k]*right[k][c] for all r,c in parallel. Keep the low W bits of the product and of the sum.
  - When k==N-1, go to DONE. io_out_valid=1 at t+N+1 (latency N+1).
  - For N=1, COMPUTE lasts exactly one cycle.
- DONE:
  - io_out_valid=1. io_out_bits_* stay stable until the output handshake, with no change under backpressure.
  - On io_out_ready: go to IDLE, increment io_opCount, drop io_out_valid next cycle.
  - io_in_ready returns the following cycle. There is no same-cycle turnaround; maximum throughput for element-wise ops is 1 op per 2 cycles.
- Overflow: every op wraps modulo 2^W.
  - SUB underflow yields two's-complement wrap, e.g. 0-1 = 2^W-1.
  - MUL keeps the low W bits only.
- Inputs are ignored in COMPUTE and DONE (io_in_ready=0). A held io_in_valid is not consumed until IDLE.
- io_out_bits_data keeps its last value after the handshake and is updated only at the next result.
- Reset asserted mid-COMPUTE or mid-DONE:
  - Immediately returns to IDLE and clears io_out_valid and the accumulator.
  - The in-flight op is discarded and io_opCount is cleared.
- io_opCount wraps 2^CNT_W-1 -> 0.

Decomposition:
- Shared package typ_tile_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_MATMUL;
  - state enum IDLE/COMPUTE/DONE;
  - element-slice helper (r,c,N,W) -> bit offset.
- One sub-module, typ_elem_alu, instantiated N*N times.
  - Inputs: a, b, acc, op, acc_en. Output: W-bit result.
  - Implements add/sub/mul/multiply-accumulate.
- The top module holds the FSM, the k counter (width clog2(N), minimum 1), the operand/result registers and io_opCount.

Test Plan:
- N=2, W=32, ADD, left {1,2,3,4}, right {10,20,30,40}, io_out_ready=1 -> io_out_valid at accept+1 with data {11,22,33,44}, op=0; io_opCount=1.
- SUB with left {0,5,0,7}, right {1,5,2,0} -> {0xFFFFFFFF,0,0xFFFFFFFE,7}. MUL with 0x10000*0x10000 -> 0 (low W bits).
- MATMUL with left {1,2,3,4}, right {5,6,7,8} -> io_out_valid first at accept+3 with data {19,22,43,50}; io_in_ready=0 on cycles accept+1..accept+3.
- Backpressure: after ADD, io_out_ready=0 for 5 cycles -> io_out_valid stays 1, data stable, io_in_ready=0 throughout, io_opCount unchanged. Raise io_out_ready -> one handshake, io_in_ready=1 next cycle.
- Reset pulse mid-MATMUL (cycle accept+1) -> io_out_valid=0, io_in_ready=1 after reset falls, io_opCount=0. A following ADD completes correctly with no residue from the discarded op.
- Parameter sweep N=1,W=8 and N=4,W=16 against a reference model, with random ops and random valid/ready:
  - results match the model;
  - io_opCount equals the number of output handshakes;
  - with CNT_W=4, io_opCount wraps from 15 to 0 after 16 ops.
